sound_scheduler: RTL

SOUND_SCHEDULER -- requirements
Module: sound_scheduler

---
 rtl/sound_scheduler.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/sound_scheduler.sv
// Tone scheduler: edge-detects game events, queues one pending tone per class and plays them bad > good > dir with a silent gap.
// Optional macro SOUND_PREEMPT_EN: a bad event cuts short a playing good/dir tone.
module sound_scheduler #(
  parameter int DUR_GOOD   = 2000,
  parameter int DUR_BAD    = 4000,
  parameter int DUR_DIR    = 500,
  parameter int GAP_CYCLES = 100,
  parameter int CNT_W      = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       button_i,
  input  logic       goodColl_i,
  input  logic       badColl_i,
  input  logic [3:0] direction_i,
  output logic [1:0] tone_o,
  output logic       play_o,
  output logic       busy_o,
  output logic       mute_o
);

  typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

  localparam logic [1:0] TONE_GOOD = 2'd1;
  localparam logic [1:0] TONE_BAD  = 2'd2;
  localparam logic [1:0] TONE_DIR  = 2'd3;

  localparam logic [CNT_W-1:0] LD_GOOD = CNT_W'(DUR_GOOD - 1);
  localparam logic [CNT_W-1:0] LD_BAD  = CNT_W'(DUR_BAD - 1);
  localparam logic [CNT_W-1:0] LD_DIR  = CNT_W'(DUR_DIR - 1);
  localparam logic [CNT_W-1:0] LD_GAP  = CNT_W'(GAP_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             good_q, good_p, bad_q, bad_p, btn_q, btn_p;
  logic [3:0]       dir_q, dir_p;
  logic             pend_bad, pend_good, pend_dir;
  logic             evt_good, evt_bad, evt_dir, evt_btn, mute_enter;
  logic             eff_bad, eff_good, eff_dir;

  // Tone events are swallowed while muted so nothing queues up behind the mute.
  always_comb begin
    evt_btn    = btn_q & ~btn_p;
    evt_good   = good_q & ~good_p & ~mute_o;
    evt_bad    = bad_q & ~bad_p & ~mute_o;
    evt_dir    = (dir_q != 4'd0) && (dir_q != dir_p) && !mute_o;
    mute_enter = evt_btn & ~mute_o;
    eff_bad    = pend_bad | evt_bad;
    eff_good   = pend_good | evt_good;
    eff_dir    = pend_dir | evt_dir;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      tone_o    <= 2'd0;
      play_o    <= 1'b0;
      busy_o    <= 1'b0;
      mute_o    <= 1'b0;
      pend_bad  <= 1'b0;
      pend_good <= 1'b0;
      pend_dir  <= 1'b0;
      good_q    <= 1'b0;
      good_p    <= 1'b0;
      bad_q     <= 1'b0;
      bad_p     <= 1'b0;
      btn_q     <= 1'b0;
      btn_p     <= 1'b0;
      dir_q     <= 4'd0;
      dir_p     <= 4'd0;
    end else begin
      good_q <= goodColl_i;
      good_p <= good_q;
      bad_q  <= badColl_i;
      bad_p  <= bad_q;
      btn_q  <= button_i;
      btn_p  <= btn_q;
      dir_q  <= direction_i;
      dir_p  <= dir_q;
      if (evt_btn) mute_o <= ~mute_o;

      if (mute_enter) begin
        state     <= IDLE;
        cnt       <= '0;
        tone_o    <= 2'd0;
        play_o    <= 1'b0;
        busy_o    <= 1'b0;
        pend_bad  <= 1'b0;
        pend_good <= 1'b0;
        pend_dir  <= 1'b0;
      end else begin
        // Same-edge events are folded in, so a clear never loses a fresh set.
        pend_bad  <= eff_bad;
        pend_good <= eff_good;
        pend_dir  <= eff_dir;
        case (state)
          IDLE: begin
            if (eff_bad) begin
              state    <= PLAY;
              cnt      <= LD_BAD;
              tone_o   <= TONE_BAD;
              play_o   <= 1'b1;
              busy_o   <= 1'b1;
              pend_bad <= 1'b0;
            end else if (eff_good) begin
              state     <= PLAY;
              cnt       <= LD_GOOD;
              tone_o    <= TONE_GOOD;
              play_o    <= 1'b1;
              busy_o    <= 1'b1;
              pend_good <= 1'b0;
            end else if (eff_dir) begin
              state    <= PLAY;
              cnt      <= LD_DIR;
              tone_o   <= TONE_DIR;
              play_o   <= 1'b1;
              busy_o   <= 1'b1;
              pend_dir <= 1'b0;
            end
          end
          PLAY: begin
`ifdef SOUND_PREEMPT_EN
            if (evt_bad && tone_o != TONE_BAD) begin
              cnt      <= LD_BAD;
              tone_o   <= TONE_BAD;
              pend_bad <= pend_bad;
            end else
`endif
            if (cnt == '0) begin
              state  <= GAP;
              cnt    <= LD_GAP;
              tone_o <= 2'd0;
              play_o <= 1'b0;
            end else begin
              cnt <= cnt - CNT_W'(1);
            end
          end
          GAP: begin
            if (cnt == '0) begin
              state  <= IDLE;
              busy_o <= 1'b0;
            end else begin
              cnt <= cnt - CNT_W'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
